state_dump_engine: RTL and testbench

- Hardware successor to the bench-side register/imem/dmem dump. On a start request it halts the core, then walks the selected regions in order: register file, then instruction memory, then data memory.
- Each word is streamed out over a valid/ready interface tagged with its region and index. The core is released when the walk completes.
- Sits beside the core in top. It is driven by debug logic or a bench, and reads through dedicated debug read ports on the register file and both memories.

---
 rtl/state_dump_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_state_dump_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_engine.sv
// Halts the core and streams regs, imem, then dmem words (selected by region_mask) out as tagged beats.
// Latency: ISSUE/CAPT/SEND per word (at most one beat per 3 cycles); a stalled beat is held until out_ready.
module state_dump_engine #(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int MEM_AW     = 16,
    parameter int IDX_W      = $clog2((REG_COUNT > IMEM_WORDS)
                                      ? ((REG_COUNT > DMEM_WORDS) ? REG_COUNT : DMEM_WORDS)
                                      : ((IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS))
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              start,
    input  logic [2:0]        region_mask,
    input  logic              abort,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [4:0]        rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic [MEM_AW-1:0] imem_raddr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [MEM_AW-1:0] dmem_raddr,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [1:0]        out_region,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {S_IDLE, S_HALT, S_ISSUE, S_CAPT, S_SEND, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        mask_q, mask_d;
    logic [1:0]        region_q, region_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              halt_req_q, halt_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [1:0]        out_region_q, out_region_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic [4:0]        rf_raddr_q, rf_raddr_d;
    logic [MEM_AW-1:0] imem_raddr_q, imem_raddr_d;
    logic [MEM_AW-1:0] dmem_raddr_q, dmem_raddr_d;

    function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] r);
        case (r)
            2'd0:    return IDX_W'(REG_COUNT - 1);
            2'd1:    return IDX_W'(IMEM_WORDS - 1);
            default: return IDX_W'(DMEM_WORDS - 1);
        endcase
    endfunction

    // Mask bits for regions still to be walked after region r.
    function automatic logic [2:0] mask_above(input logic [2:0] m, input logic [1:0] r);
        case (r)
            2'd0:    return m & 3'b110;
            2'd1:    return m & 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] lowest(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    function automatic logic [MEM_AW-1:0] word_addr(input logic [IDX_W-1:0] i);
        return MEM_AW'({i, 2'b00});
    endfunction

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        region_d     = region_q;
        idx_d        = idx_q;
        halt_req_d   = halt_req_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_region_d = out_region_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        rf_raddr_d   = rf_raddr_q;
        imem_raddr_d = imem_raddr_q;
        dmem_raddr_d = dmem_raddr_q;

        // Abort outranks a same-cycle transfer; the pending beat is dropped.
        if (busy_q && abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            halt_req_d  = 1'b0;
            busy_d      = 1'b0;
            aborted_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (region_mask != 3'b000) begin
                            mask_d     = region_mask;
                            region_d   = lowest(region_mask);
                            idx_d      = '0;
                            halt_req_d = 1'b1;
                            busy_d     = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (halt_ack) state_d = S_ISSUE;
                end
                S_ISSUE: state_d = S_CAPT;
                S_CAPT: begin
                    case (region_q)
                        2'd0:    out_data_d = rf_rdata;
                        2'd1:    out_data_d = imem_rdata;
                        default: out_data_d = dmem_rdata;
                    endcase
                    out_region_d = region_q;
                    out_index_d  = idx_q;
                    out_last_d   = (idx_q == last_idx(region_q)) &&
                                   (mask_above(mask_q, region_q) == 3'b000);
                    out_valid_d  = 1'b1;
                    state_d      = S_SEND;
                end
                S_SEND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (idx_q != last_idx(region_q)) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_ISSUE;
                        end else if (mask_above(mask_q, region_q) != 3'b000) begin
                            region_d = lowest(mask_above(mask_q, region_q));
                            idx_d    = '0;
                            state_d  = S_ISSUE;
                        end else begin
                            halt_req_d = 1'b0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Address is registered on entry to ISSUE so it is stable through ISSUE and CAPT.
        if (state_d == S_ISSUE) begin
            case (region_d)
                2'd0:    rf_raddr_d   = 5'(idx_d);
                2'd1:    imem_raddr_d = word_addr(idx_d);
                default: dmem_raddr_d = word_addr(idx_d);
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            region_q     <= '0;
            idx_q        <= '0;
            halt_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_region_q <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            rf_raddr_q   <= '0;
            imem_raddr_q <= '0;
            dmem_raddr_q <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            region_q     <= region_d;
            idx_q        <= idx_d;
            halt_req_q   <= halt_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_region_q <= out_region_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            rf_raddr_q   <= rf_raddr_d;
            imem_raddr_q <= imem_raddr_d;
            dmem_raddr_q <= dmem_raddr_d;
        end
    end

    assign halt_req   = halt_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_region = out_region_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign rf_raddr   = rf_raddr_q;
    assign imem_raddr = imem_raddr_q;
    assign dmem_raddr = dmem_raddr_q;

endmodule

// File: tb/tb_state_dump_engine.sv
// Scoreboard bench for state_dump_engine: expected beats queued at start, popped on each transfer.
module tb_state_dump_engine;
    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int IMEM_WORDS = 256;
    localparam int DMEM_WORDS = 256;
    localparam int MEM_AW     = 16;
    localparam int IDX_W      = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              areset_n;
    logic              start;
    logic [2:0]        region_mask;
    logic              abort;
    logic              halt_req;
    logic              halt_ack;
    logic [4:0]        rf_raddr;
    logic [XLEN-1:0]   rf_rdata;
    logic [MEM_AW-1:0] imem_raddr;
    logic [XLEN-1:0]   imem_rdata;
    logic [MEM_AW-1:0] dmem_raddr;
    logic [XLEN-1:0]   dmem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [1:0]        out_region;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              aborted;

    state_dump_engine #(
        .XLEN(XLEN), .REG_COUNT(REG_COUNT), .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS), .MEM_AW(MEM_AW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .areset_n(areset_n), .start(start), .region_mask(region_mask),
        .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_region(out_region), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done), .aborted(aborted)
    );

    // Memory models: regs and imem read combinationally, dmem with one cycle of read latency.
    logic [31:0] regs   [REG_COUNT];
    logic [7:0]  imem_b [IMEM_WORDS*4];
    logic [7:0]  dmem_b [DMEM_WORDS*4];

    assign rf_rdata   = regs[rf_raddr];
    assign imem_rdata = {imem_b[int'(imem_raddr)+3], imem_b[int'(imem_raddr)+2],
                         imem_b[int'(imem_raddr)+1], imem_b[int'(imem_raddr)]};
    always @(posedge clk)
        dmem_rdata <= {dmem_b[int'(dmem_raddr)+3], dmem_b[int'(dmem_raddr)+2],
                       dmem_b[int'(dmem_raddr)+1], dmem_b[int'(dmem_raddr)]};

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  region;
        logic [7:0]  index;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_seen = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int beat_count(input logic [2:0] m);
        return (m[0] ? REG_COUNT : 0) + (m[1] ? IMEM_WORDS : 0) + (m[2] ? DMEM_WORDS : 0);
    endfunction

    task automatic push_expected(input logic [2:0] m);
        int    depth [3];
        int    last_r;
        beat_t b;
        depth  = '{REG_COUNT, IMEM_WORDS, DMEM_WORDS};
        last_r = -1;
        for (int r = 0; r < 3; r++) if (m[r]) last_r = r;
        for (int r = 0; r < 3; r++) begin
            if (m[r]) begin
                for (int i = 0; i < depth[r]; i++) begin
                    if (r == 0)      b.data = regs[i];
                    else if (r == 1) b.data = {imem_b[4*i+3], imem_b[4*i+2], imem_b[4*i+1], imem_b[4*i]};
                    else             b.data = {dmem_b[4*i+3], dmem_b[4*i+2], dmem_b[4*i+1], dmem_b[4*i]};
                    b.region = 2'(r);
                    b.index  = 8'(i);
                    b.last   = (r == last_r) && (i == depth[r] - 1);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Monitor: inputs change just after posedge, so at negedge they are what the next edge samples.
    initial begin
        bit          stall_prev;
        logic [63:0] prev_payload;
        beat_t       b;
        stall_prev   = 1'b0;
        prev_payload = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && out_valid)
                check("hold_stable", 64'({out_data, out_region, out_index, out_last}), prev_payload);
            if (out_valid && out_ready && !abort && areset_n) begin
                beats_seen++;
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("beat_data",   64'(out_data),   64'(b.data));
                    check("beat_region", 64'(out_region), 64'(b.region));
                    check("beat_index",  64'(out_index),  64'(b.index));
                    check("beat_last",   64'(out_last),   64'(b.last));
                    if (b.region == 2'd0)      check("rf_addr",   64'(rf_raddr),   64'(b.index));
                    else if (b.region == 2'd1) check("imem_addr", 64'(imem_raddr), 64'(b.index) * 4);
                    else                       check("dmem_addr", 64'(dmem_raddr), 64'(b.index) * 4);
                end
            end
            stall_prev   = out_valid && !out_ready && !abort && areset_n;
            prev_payload = 64'({out_data, out_region, out_index, out_last});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic run_dump(input logic [2:0] m, input int ack_delay, input bit mid_start,
                            input bit with_abort, input string tag);
        int base;
        bit got_done;
        push_expected(m);
        base        = beats_seen;
        start       = 1'b1;
        region_mask = m;
        abort       = with_abort;
        step();
        start       = 1'b0;
        region_mask = 3'b000;
        abort       = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'(1));
        repeat (ack_delay) step();
        check({tag, "_halt_req"}, 64'(halt_req), 64'(1));
        halt_ack = 1'b1;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
            if (mid_start && cyc == 40) begin
                start       = 1'b1;
                region_mask = 3'b110;
            end
            step();
            start       = 1'b0;
            region_mask = 3'b000;
            if (done) got_done = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got_done), 64'(1));
        check({tag, "_halt_dropped"}, 64'(halt_req), 64'(0));
        check({tag, "_not_busy"}, 64'(busy), 64'(0));
        check({tag, "_beats"}, 64'(beats_seen - base), 64'(beat_count(m)));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
        halt_ack = 1'b0;
        step();
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        int  base;
        bit  found;
        bit  stray;
        areset_n    = 1'b0;
        start       = 1'b0;
        region_mask = 3'b000;
        abort       = 1'b0;
        halt_ack    = 1'b0;
        out_ready   = 1'b1;
        regs[0] = 32'h0;
        for (int i = 1; i < REG_COUNT; i++) regs[i] = $urandom;
        for (int i = 0; i < IMEM_WORDS*4; i++) imem_b[i] = 8'($urandom);
        for (int i = 0; i < DMEM_WORDS*4; i++) dmem_b[i] = 8'($urandom);

        #22;
        check("rst_halt_req",  64'(halt_req),   64'(0));
        check("rst_busy",      64'(busy),       64'(0));
        check("rst_done",      64'(done),       64'(0));
        check("rst_aborted",   64'(aborted),    64'(0));
        check("rst_out_valid", 64'(out_valid),  64'(0));
        check("rst_out_data",  64'(out_data),   64'(0));
        check("rst_out_last",  64'(out_last),   64'(0));
        check("rst_addrs",     64'({rf_raddr, imem_raddr, dmem_raddr}), 64'(0));
        step();
        areset_n = 1'b1;
        step();

        run_dump(3'b001, 3, 1'b0, 1'b0, "regs");
        run_dump(3'b110, 1, 1'b0, 1'b0, "mems");

        rand_ready = 1'b1;
        run_dump(3'b101, 2, 1'b0, 1'b0, "bp");
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        step();

        // Abort while reg beat 10 is being offered with out_ready high.
        push_expected(3'b001);
        base        = beats_seen;
        start       = 1'b1;
        region_mask = 3'b001;
        step();
        start       = 1'b0;
        halt_ack    = 1'b1;
        found       = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            step();
            if (out_valid && out_index == 8'd10) found = 1'b1;
        end
        check("abort_reach_idx10", 64'(found), 64'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_pulse",     64'(aborted),   64'(1));
        check("abort_halt_req",  64'(halt_req),  64'(0));
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_no_done",   64'(done),      64'(0));
        check("abort_beats",     64'(beats_seen - base), 64'(10));
        stray = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (done || aborted || out_valid) stray = 1'b1;
        end
        check("abort_quiet_after", 64'(stray), 64'(0));
        exp_q.delete();
        halt_ack = 1'b0;

        // Empty mask completes at once without halting.
        start       = 1'b1;
        region_mask = 3'b000;
        step();
        start = 1'b0;
        check("mask0_done",     64'(done),     64'(1));
        check("mask0_halt_req", 64'(halt_req), 64'(0));
        check("mask0_busy",     64'(busy),     64'(0));
        step();
        check("mask0_done_pulse", 64'(done),     64'(0));
        check("mask0_no_beat",    64'(out_valid), 64'(0));

        run_dump(3'b001, 1, 1'b1, 1'b0, "midstart");
        run_dump(3'b100, 2, 1'b0, 1'b1, "start_abort");

        // Asynchronous reset in the middle of an imem walk.
        push_expected(3'b010);
        start       = 1'b1;
        region_mask = 3'b010;
        step();
        start       = 1'b0;
        region_mask = 3'b000;
        halt_ack    = 1'b1;
        repeat (40) step();
        check("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        areset_n = 1'b0;
        #1;
        check("arst_halt_req",  64'(halt_req),   64'(0));
        check("arst_busy",      64'(busy),       64'(0));
        check("arst_out_valid", 64'(out_valid),  64'(0));
        check("arst_out_data",  64'(out_data),   64'(0));
        check("arst_out_index", 64'(out_index),  64'(0));
        check("arst_imem_addr", 64'(imem_raddr), 64'(0));
        exp_q.delete();
        halt_ack = 1'b0;
        step();
        step();
        areset_n = 1'b1;
        step();
        run_dump(3'b111, 2, 1'b0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
